// File: rtl/iob_uart16550_ctrl_pkg.sv
// Shared definitions for the iob_uart16550 controller: UART register
// offsets, the constants written during configuration, LSR bit positions,
// the controller state encoding and the configuration write table.
package iob_uart16550_ctrl_pkg;

  // UART register byte offsets
  localparam logic [2:0] REG_RBR_THR = 3'd0;
  localparam logic [2:0] REG_IER     = 3'd1;
  localparam logic [2:0] REG_FCR     = 3'd2;
  localparam logic [2:0] REG_LCR     = 3'd3;
  localparam logic [2:0] REG_LSR     = 3'd5;
  // DLL/DLM alias RBR/IER while LCR.DLAB is set
  localparam logic [2:0] REG_DLL     = 3'd0;
  localparam logic [2:0] REG_DLM     = 3'd1;

  // 8N1 with DLAB set, then 8N1 with DLAB cleared
  localparam logic [7:0] LCR_DLAB_8N1 = 8'h83;
  localparam logic [7:0] LCR_8N1      = 8'h03;
  // FIFO enable + clear RX and TX FIFOs
  localparam logic [7:0] FCR_INIT     = 8'h07;
  // interrupts unused: the controller polls LSR
  localparam logic [7:0] IER_INIT     = 8'h00;

  localparam int LSR_DR     = 0;
  localparam int LSR_ERR_LO = 1;
  localparam int LSR_ERR_HI = 4;
  localparam int LSR_THRE   = 5;

  localparam logic [2:0] CFG_LAST_STEP = 3'd5;

  typedef enum logic [2:0] {
    ST_CONFIG  = 3'd0,
    ST_IDLE    = 3'd1,
    ST_POLL    = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_DO_TX   = 3'd4,
    ST_DO_RX   = 3'd5
  } state_t;

  typedef struct packed {
    logic [2:0] off;
    logic [7:0] data;
  } cfg_wr_t;

  // Register/value pair for each step of the configuration sequence.
  function automatic cfg_wr_t cfg_write(input logic [2:0] step, input logic [15:0] div);
    cfg_wr_t w;
    w.off  = REG_LCR;
    w.data = LCR_DLAB_8N1;
    case (step)
      3'd1:    begin w.off = REG_DLL; w.data = div[7:0];  end
      3'd2:    begin w.off = REG_DLM; w.data = div[15:8]; end
      3'd3:    begin w.off = REG_LCR; w.data = LCR_8N1;   end
      3'd4:    begin w.off = REG_FCR; w.data = FCR_INIT;  end
      3'd5:    begin w.off = REG_IER; w.data = IER_INIT;  end
      default: begin w.off = REG_LCR; w.data = LCR_DLAB_8N1; end
    endcase
    return w;
  endfunction

endpackage

// File: rtl/iob_uart16550_ctrl_bus.sv
// Single-transaction IOb master. A request (i_req while idle) is latched and
// presented on the bus until accepted; writes complete on the accept cycle,
// reads complete when rvalid arrives (same cycle as accept or later).
// Ports:
//   i_clk, i_cke, i_arst_n      clock, clock enable, async active-low reset
//   i_req/i_we/i_addr/i_wbyte   transaction request (taken only when idle)
//   o_done                      one-cycle completion strobe
//   o_rbyte                     read byte from the addressed lane (valid with o_done)
//   o_iob_* / i_iob_*           IOb master interface
module iob_uart16550_ctrl_bus #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                  i_clk,
  input  logic                  i_cke,
  input  logic                  i_arst_n,
  input  logic                  i_req,
  input  logic                  i_we,
  input  logic [ADDR_W-1:0]     i_addr,
  input  logic [7:0]            i_wbyte,
  output logic                  o_done,
  output logic [7:0]            o_rbyte,
  output logic                  o_iob_avalid,
  output logic [ADDR_W-1:0]     o_iob_addr,
  output logic [DATA_W-1:0]     o_iob_wdata,
  output logic [DATA_W/8-1:0]   o_iob_wstrb,
  input  logic                  i_iob_rvalid,
  input  logic [DATA_W-1:0]     i_iob_rdata,
  input  logic                  i_iob_ready
);

  localparam int STRB_W = DATA_W / 8;

  logic              r_avalid;
  logic              r_rd_wait;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_wbyte;

  logic w_accept;
  logic w_start;

  assign w_accept = r_avalid & i_iob_ready;
  assign w_start  = i_req & ~r_avalid & ~r_rd_wait;

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_avalid  <= 1'b0;
      r_rd_wait <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wbyte   <= '0;
    end else if (i_cke) begin
      if (w_start) begin
        r_avalid <= 1'b1;
        r_we     <= i_we;
        r_addr   <= i_addr;
        r_wbyte  <= i_wbyte;
      end else if (w_accept) begin
        r_avalid  <= 1'b0;
        // read data may arrive on the accept cycle itself
        r_rd_wait <= ~r_we & ~i_iob_rvalid;
      end else if (r_rd_wait && i_iob_rvalid) begin
        r_rd_wait <= 1'b0;
      end
    end
  end

  assign o_done = i_cke & ((w_accept & (r_we | i_iob_rvalid)) | (r_rd_wait & i_iob_rvalid));
  assign o_rbyte = i_iob_rdata[8*r_addr[1:0] +: 8];

  assign o_iob_avalid = r_avalid;
  assign o_iob_addr   = r_addr;
  assign o_iob_wdata  = {STRB_W{r_wbyte}};
  assign o_iob_wstrb  = r_we ? (STRB_W'(1) << r_addr[1:0]) : '0;

endmodule

// File: rtl/iob_uart16550_ctrl.sv
// IOb master that configures an iob_uart16550 and then shuttles bytes
// between a TX valid/ready stream, an RX valid/ready stream and the UART
// THR/RBR, gated by polled LSR status.
// Ports:
//   clk_i, cke_i, arst_n_i        clock, clock enable, async active-low reset
//   div_i, cfg_start_i            baud divisor, reconfiguration request pulse
//   cfg_done_o                    UART configured, streams live
//   tx_data_i/valid_i/ready_o     byte stream towards the UART
//   rx_data_o/valid_o/ready_i     byte stream from the UART
//   lsr_err_o                     sticky LSR[4:1] {BI, FE, PE, OE}
//   iob_*                         IOb master interface to the UART
module iob_uart16550_ctrl
  import iob_uart16550_ctrl_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                  clk_i,
  input  logic                  cke_i,
  input  logic                  arst_n_i,
  input  logic [15:0]           div_i,
  input  logic                  cfg_start_i,
  output logic                  cfg_done_o,
  input  logic [7:0]            tx_data_i,
  input  logic                  tx_valid_i,
  output logic                  tx_ready_o,
  output logic [7:0]            rx_data_o,
  output logic                  rx_valid_o,
  input  logic                  rx_ready_i,
  output logic [3:0]            lsr_err_o,
  output logic                  iob_avalid_o,
  output logic [ADDR_W-1:0]     iob_addr_o,
  output logic [DATA_W-1:0]     iob_wdata_o,
  output logic [DATA_W/8-1:0]   iob_wstrb_o,
  input  logic                  iob_rvalid_i,
  input  logic [DATA_W-1:0]     iob_rdata_i,
  input  logic                  iob_ready_i
);

  state_t      r_state;
  logic [2:0]  r_step;
  logic [15:0] r_div;
  logic        r_issued;    // request for the current state handed to the bus
  logic        r_cfg_done;
  logic        r_cfg_pend;
  logic        r_tx_full;
  logic [7:0]  r_tx_byte;
  logic        r_rx_full;
  logic [7:0]  r_rx_byte;
  logic [3:0]  r_lsr_err;
  logic        r_last_tx;   // 1: TX served last, 0: RX served last

  logic        w_req;
  logic        w_we;
  logic [2:0]  w_reg;
  logic [7:0]  w_wbyte;
  logic        w_done;
  logic [7:0]  w_rbyte;
  cfg_wr_t     w_cfg;
  logic        w_tx_ready;
  logic        w_tx_load;
  logic        w_tx_clr;
  logic        w_rx_set;
  logic        w_tx_ok;
  logic        w_rx_ok;
  logic        w_cfg_take;

  assign w_cfg      = cfg_write(r_step, r_div);
  assign w_tx_ready = r_cfg_done & ~r_tx_full;
  assign w_tx_load  = tx_valid_i & w_tx_ready;
  assign w_tx_clr   = (r_state == ST_DO_TX) & w_done;
  assign w_rx_set   = (r_state == ST_DO_RX) & w_done;
  assign w_tx_ok    = r_tx_full & w_rbyte[LSR_THRE];
  assign w_rx_ok    = ~r_rx_full & w_rbyte[LSR_DR];
  assign w_cfg_take = (r_state == ST_IDLE) & r_cfg_pend;

  // Bus request for the current state; issued once, then wait for done.
  always_comb begin
    w_req   = 1'b0;
    w_we    = 1'b0;
    w_reg   = REG_RBR_THR;
    w_wbyte = 8'h00;
    case (r_state)
      ST_CONFIG: begin
        w_req   = ~r_issued;
        w_we    = 1'b1;
        w_reg   = w_cfg.off;
        w_wbyte = w_cfg.data;
      end
      ST_POLL: begin
        w_req = 1'b1;
        w_reg = REG_LSR;
      end
      ST_DO_TX: begin
        w_req   = ~r_issued;
        w_we    = 1'b1;
        w_wbyte = r_tx_byte;
      end
      ST_DO_RX: w_req = ~r_issued;
      default: ;
    endcase
  end

  iob_uart16550_ctrl_bus #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_bus (
    .i_clk        (clk_i),
    .i_cke        (cke_i),
    .i_arst_n     (arst_n_i),
    .i_req        (w_req),
    .i_we         (w_we),
    .i_addr       (ADDR_W'(w_reg)),
    .i_wbyte      (w_wbyte),
    .o_done       (w_done),
    .o_rbyte      (w_rbyte),
    .o_iob_avalid (iob_avalid_o),
    .o_iob_addr   (iob_addr_o),
    .o_iob_wdata  (iob_wdata_o),
    .o_iob_wstrb  (iob_wstrb_o),
    .i_iob_rvalid (iob_rvalid_i),
    .i_iob_rdata  (iob_rdata_i),
    .i_iob_ready  (iob_ready_i)
  );

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_state    <= ST_CONFIG;
      r_step     <= 3'd0;
      r_div      <= 16'h0000;
      r_issued   <= 1'b0;
      r_cfg_done <= 1'b0;
      r_cfg_pend <= 1'b0;
      r_tx_full  <= 1'b0;
      r_tx_byte  <= 8'h00;
      r_rx_full  <= 1'b0;
      r_rx_byte  <= 8'h00;
      r_lsr_err  <= 4'h0;
      r_last_tx  <= 1'b0;
    end else if (cke_i) begin
      if (w_req)       r_issued <= 1'b1;
      else if (w_done) r_issued <= 1'b0;

      r_cfg_pend <= w_cfg_take ? 1'b0 : (r_cfg_pend | cfg_start_i);

      // Buffer flags: stream-side and bus-side events may coincide
      if (w_tx_load) r_tx_byte <= tx_data_i;
      if (w_tx_load)     r_tx_full <= 1'b1;
      else if (w_tx_clr) r_tx_full <= 1'b0;

      if (w_rx_set) begin
        r_rx_full <= 1'b1;
        r_rx_byte <= w_rbyte;
      end else if (rx_ready_i) begin
        r_rx_full <= 1'b0;
      end

      case (r_state)
        ST_CONFIG: begin
          // divisor sampled on the first cycle of the sequence
          if (w_req && r_step == 3'd0) r_div <= div_i;
          if (w_done) begin
            if (r_step == CFG_LAST_STEP) begin
              r_step     <= 3'd0;
              r_cfg_done <= 1'b1;
              r_state    <= ST_IDLE;
            end else begin
              r_step <= r_step + 3'd1;
            end
          end
        end
        ST_IDLE: begin
          if (r_cfg_pend) begin
            r_cfg_done <= 1'b0;
            r_lsr_err  <= 4'h0;
            r_step     <= 3'd0;
            r_state    <= ST_CONFIG;
          end else if ((r_tx_full || !r_rx_full) && r_cfg_done) begin
            r_state <= ST_POLL;
          end
        end
        ST_POLL: r_state <= ST_RD_WAIT;
        ST_RD_WAIT: begin
          if (w_done) begin
            r_lsr_err <= r_lsr_err | w_rbyte[LSR_ERR_HI:LSR_ERR_LO];
            if (w_tx_ok && w_rx_ok) r_state <= r_last_tx ? ST_DO_RX : ST_DO_TX;
            else if (w_tx_ok)       r_state <= ST_DO_TX;
            else if (w_rx_ok)       r_state <= ST_DO_RX;
            else                    r_state <= ST_IDLE;
          end
        end
        ST_DO_TX: begin
          if (w_done) begin
            r_last_tx <= 1'b1;
            r_state   <= ST_IDLE;
          end
        end
        ST_DO_RX: begin
          if (w_done) begin
            r_last_tx <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end
        default: r_state <= ST_CONFIG;
      endcase
    end
  end

  assign cfg_done_o = r_cfg_done;
  assign tx_ready_o = w_tx_ready;
  assign rx_valid_o = r_rx_full;
  assign rx_data_o  = r_rx_byte;
  assign lsr_err_o  = r_lsr_err;

endmodule

// File: doc/iob_uart16550_ctrl.md
Name: iob_uart16550_ctrl

Overview:
- IOb-bus master that sequences an iob_uart16550 instance: programs baud divisor, line format and FIFOs after reset or on request.
- Then polls LSR and moves bytes between two valid/ready byte streams (TX in, RX out) and the UART THR/RBR.
- Sits between a simple streaming client (DMA, console bridge) and the UART's CPU port, replacing software drivers.

Parameters:
- ADDR_W, 5, IOb byte-address width (UART register space).
- DATA_W, 32, IOb data width; byte lane of register r is r[1:0].

Ports:
- clk_i  in  1  clock
- cke_i  in  1  clock enable; all state holds when 0
- arst_n_i  in  1  asynchronous active-low reset
- div_i  in  16  baud divisor, sampled on entry to CONFIG
- cfg_start_i  in  1  pulse: request reconfiguration
- cfg_done_o  out  1  UART configured, streams live
- tx_data_i  in  8  byte to transmit
- tx_valid_i  in  1  TX handshake
- tx_ready_o  out  1  TX handshake
- rx_data_o  out  8  received byte
- rx_valid_o  out  1  RX handshake
- rx_ready_i  in  1  RX handshake
- lsr_err_o  out  4  sticky LSR[4:1] (BI, FE, PE, OE)
- iob_avalid_o  out  1  request valid
- iob_addr_o  out  ADDR_W  register byte address
- iob_wdata_o  out  DATA_W  write data, byte replicated on all lanes
- iob_wstrb_o  out  DATA_W/8  1<<addr[1:0] for writes, 0 for reads
- iob_rvalid_i  in  1  read data valid
- iob_rdata_i  in  DATA_W  read data
- iob_ready_i  in  1  request accepted

Behaviour:
- Single clock, asynchronous active-low reset (arst_n_i). Reset: all outputs 0, tx/rx buffers empty, lsr_err_o=0, state CONFIG step 0; an in-flight request is abandoned (avalid drops immediately).
- IOb rules: avalid, addr, wdata, wstrb held stable until the cycle avalid&ready. Write completes that cycle. Read then waits for rvalid (same cycle or later) and takes byte rdata[8*addr[1:0]+:8]. One outstanding transaction max.
- States: CONFIG, IDLE, POLL, RD_WAIT, DO_TX, DO_RX.
- CONFIG issues six writes in order:
  - LCR(3)=0x83
  - DLL(0)=div[7:0]
  - DLM(1)=div[15:8]
  - LCR(3)=0x03
  - FCR(2)=0x07
  - IER(1)=0x00
  - div latched on entry. On completion of the last write: cfg_done_o=1, go to IDLE.
- cfg_start_i: sets a pending flag. Taken in IDLE only, never mid-transaction. Clears cfg_done_o and lsr_err_o, then enters CONFIG. tx/rx buffers are preserved.
- TX buffer: one entry. tx_ready_o = cfg_done_o & ~tx_full. Load on tx_valid_i & tx_ready_o.
- RX buffer: one entry. rx_valid_o = rx_full. Cleared on rx_ready_i.
- IDLE → POLL when (tx_full | ~rx_full) & cfg_done_o. Otherwise stay; no bus traffic.
- POLL reads LSR(5), then RD_WAIT. On rvalid, lsr_err_o |= LSR[4:1]. Eligibility:
  - tx_ok = tx_full & LSR[5]
  - rx_ok = ~rx_full & LSR[0]
- Dispatch after the LSR read:
  - Both eligible: serve the one not served last (1-bit last_served, reset = RX), so the first service is TX.
  - One eligible: serve it.
  - None eligible: back to IDLE.
- DO_TX writes THR(0)=tx byte. At the accept cycle: tx_full=0, then IDLE.
- DO_RX reads RBR(0). On rvalid: rx_data_o=byte, rx_full=1, then IDLE.
- A TX load or RX drain in the same cycle as a bus event is honoured; buffer flags use set/clear priority so neither is lost.
- Latency: idle UART to THR write ≥ 2 bus transactions (LSR read + write).

Decomposition:
- Shared package (iob_uart16550_ctrl_pkg): register offsets (RBR_THR=0, IER=1, FCR=2, LCR=3, LSR=5), LCR/FCR config constants, LSR bit indices, state encoding.
- One natural sub-module, iob_uart16550_ctrl_bus: the single-transaction IOb master (req/we/addr/byte in → done/rbyte out), reused by every state.

Test Plan:
- Reset release with div_i=0x0145, ready tied 1 → exactly the six writes in order: addr 3 data 0x83; 0 0x45; 1 0x01; 3 0x03; 2 0x07; 1 0x00. Then cfg_done_o=1.
- tx 0x41 and LSR=0x60 → LSR read at addr 5 (wstrb 0), then write addr 0 with wstrb 0001 and wdata 0x41414141; tx_ready_o returns 1.
- LSR=0x61, rx buffer empty, tx pending 0x55 → TX served first, next poll RX: rx_data_o = rdata[7:0] = 0x5A, rx_valid_o held until rx_ready_i.
- ready delayed 3 cycles, rvalid 2 cycles after ready → avalid/addr stable throughout, no second request issued.
- LSR=0x0B (OE, FE set) → lsr_err_o=0x5 sticky; cfg_start_i pulse clears it and replays config after the current transaction finishes.
- arst_n_i low during DO_TX with avalid high → avalid 0 asynchronously; after release the config sequence restarts from LCR=0x83.
